// File: rtl/bg_pattern_fader.sv
// bg_pattern_fader: four-pattern VGA background (RRRGGGBB) whose mode changes
// cross-fade through black, one brightness step per FADE_FRAMES frames.
module bg_pattern_fader #(
    parameter int X_SIZE      = 640,
    parameter int Y_SIZE      = 480,
    parameter int BORDER      = 10,
    parameter int TILE_LOG2   = 5,
    parameter int FADE_FRAMES = 1
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic [1:0]  bgState,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    output logic [7:0]  BG_RGB,
    output logic        fadeBusy
);
    localparam logic [10:0] XS      = 11'(X_SIZE);
    localparam logic [10:0] YS      = 11'(Y_SIZE);
    localparam logic [10:0] BD      = 11'(BORDER);
    localparam logic [3:0]  FF_LAST = 4'(FADE_FRAMES - 1);

    typedef enum logic [1:0] {IDLE, FADE_OUT, SWAP, FADE_IN} state_t;

    state_t      state_q, state_d;
    logic [3:0]  level_q, level_d, div_q, div_d;
    logic [1:0]  mode_q, mode_d, target_q, target_d;
    logic [10:0] off_q, off_d;
    logic        busy_q, busy_d;
    logic [7:0]  rgb_q, rgb_d, pat;
    logic [10:0] sx_raw, sx;
    logic [2:0]  idx, r_o, g_o;
    logic [1:0]  b_o;
    logic        border, chk, in_frame, step;

    always_comb begin
        in_frame = (pixelX < XS) && (pixelY < YS);
        border   = (pixelX < BD) || (pixelX >= XS - BD) || (pixelY < BD) || (pixelY >= YS - BD);
        chk      = 1'((pixelX >> TILE_LOG2) ^ (pixelY >> TILE_LOG2));
        sx_raw   = pixelX + off_q;
        sx       = (sx_raw >= XS) ? sx_raw - XS : sx_raw;
        idx      = 3'(sx >> TILE_LOG2);
        pat      = (mode_q == 2'd0) ? 8'h10 :
                   (mode_q == 2'd1) ? (border ? 8'hFF : 8'h03) :
                   (mode_q == 2'd2) ? (chk ? 8'h49 : 8'h92) : {idx, ~idx, 2'b01};
        r_o      = 3'(({3'b0, pat[7:5]} * {2'b0, level_q}) >> 3);
        g_o      = 3'(({3'b0, pat[4:2]} * {2'b0, level_q}) >> 3);
        b_o      = 2'(({4'b0, pat[1:0]} * {2'b0, level_q}) >> 3);
        rgb_d    = in_frame ? {r_o, g_o, b_o} : 8'h00;
    end

    // All FSM activity is gated by startOfFrame so transitions never tear a frame.
    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        div_d    = div_q;
        mode_d   = mode_q;
        target_d = target_q;
        busy_d   = busy_q;
        off_d    = off_q;
        step     = (div_q == FF_LAST);
        if (startOfFrame) begin
            off_d = (off_q == XS - 11'd1) ? 11'd0 : off_q + 11'd1;
            div_d = step ? 4'd0 : div_q + 4'd1;
            case (state_q)
                IDLE: begin
                    div_d = 4'd0;
                    if (bgState != mode_q) begin
                        target_d = bgState;
                        busy_d   = 1'b1;
                        state_d  = FADE_OUT;
                    end
                end
                FADE_OUT: if (step) begin
                    level_d = level_q - 4'd1;
                    if (level_q == 4'd1) state_d = SWAP;
                end
                SWAP: begin
                    div_d   = 4'd0;
                    mode_d  = target_q;
                    state_d = FADE_IN;
                end
                default: if (step) begin
                    level_d = level_q + 4'd1;
                    if (level_q == 4'd7) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q  <= IDLE;
            level_q  <= 4'd8;
            div_q    <= 4'd0;
            mode_q   <= 2'd0;
            target_q <= 2'd0;
            off_q    <= 11'd0;
            busy_q   <= 1'b0;
            rgb_q    <= 8'h00;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            div_q    <= div_d;
            mode_q   <= mode_d;
            target_q <= target_d;
            off_q    <= off_d;
            busy_q   <= busy_d;
            rgb_q    <= rgb_d;
        end
    end

    assign BG_RGB   = rgb_q;
    assign fadeBusy = busy_q;
endmodule

// File: tb/tb_bg_pattern_fader.sv
// tb_bg_pattern_fader: directed and randomized checks of bg_pattern_fader
// against a frame-level reference model of patterns and fade progress.
module tb_bg_pattern_fader;
    logic        clk = 1'b0;
    logic        resetN;
    logic        startOfFrame;
    logic [1:0]  bgState;
    logic [10:0] pixelX, pixelY;
    logic [7:0]  BG_RGB;
    logic        fadeBusy;

    int errors = 0;
    int checks = 0;

    // Reference state: fade progress is a step count 0..17 since the request.
    int m_mode, m_target, m_off, m_step;
    bit m_busy;

    bg_pattern_fader #(.X_SIZE(640), .Y_SIZE(480), .BORDER(10), .TILE_LOG2(5), .FADE_FRAMES(1)) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .bgState(bgState),
        .pixelX(pixelX), .pixelY(pixelY), .BG_RGB(BG_RGB), .fadeBusy(fadeBusy)
    );

    always #5 clk = ~clk;

    function automatic int ref_level();
        if (!m_busy) return 8;
        if (m_step <= 8) return 8 - m_step;
        if (m_step == 9) return 0;
        return m_step - 9;
    endfunction

    function automatic logic [7:0] ref_rgb(int x, int y);
        int r, g, b, lv, idx;
        if (x >= 640 || y >= 480) return 8'h00;
        case (m_mode)
            0: begin r = 0; g = 4; b = 0; end
            1: if (x < 10 || x >= 630 || y < 10 || y >= 470) begin r = 7; g = 7; b = 3; end
               else begin r = 0; g = 0; b = 3; end
            2: if (((x / 32) + (y / 32)) % 2 == 0) begin r = 4; g = 4; b = 2; end
               else begin r = 2; g = 2; b = 1; end
            default: begin
                idx = (((x + m_off) % 640) / 32) % 8;
                r = idx; g = 7 - idx; b = 1;
            end
        endcase
        lv = ref_level();
        return 8'((r * lv / 8) * 32 + (g * lv / 8) * 4 + (b * lv / 8));
    endfunction

    task automatic model_reset();
        m_mode = 0; m_target = 0; m_off = 0; m_step = 0; m_busy = 0;
    endtask

    task automatic model_sof(int bg);
        m_off = (m_off + 1) % 640;
        if (!m_busy) begin
            if (bg != m_mode) begin
                m_target = bg; m_busy = 1; m_step = 0;
            end
        end else begin
            m_step++;
            if (m_step == 9) m_mode = m_target;
            if (m_step == 17) m_busy = 0;
        end
    endtask

    task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(logic sof, logic [1:0] bg, logic [10:0] x, logic [10:0] y);
        logic [7:0] e;
        startOfFrame = sof; bgState = bg; pixelX = x; pixelY = y;
        e = ref_rgb(int'(x), int'(y));
        @(posedge clk);
        if (sof) model_sof(int'(bg));
        @(negedge clk);
        startOfFrame = 1'b0;
        check("rgb", BG_RGB, e);
        check("busy", {7'b0, fadeBusy}, {7'b0, m_busy});
    endtask

    initial begin
        int edge_x[7];
        int edge_y[5];
        logic [1:0] bg;
        edge_x = '{0, 9, 10, 629, 630, 639, 640};
        edge_y = '{0, 9, 470, 479, 480};
        resetN = 1'b0; startOfFrame = 1'b0; bgState = 2'd0; pixelX = 11'd100; pixelY = 11'd100;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_rgb", BG_RGB, 8'h00);
        check("reset_busy", {7'b0, fadeBusy}, 8'h00);
        resetN = 1'b1;
        tick(0, 0, 100, 100);
        check("mode0_const", BG_RGB, 8'h10);
        // Fade 0 -> 1 from SOF n.
        tick(1, 1, 100, 100);
        check("busy_start", {7'b0, fadeBusy}, 8'h01);
        repeat (4) tick(1, 1, 100, 100);
        tick(0, 1, 100, 100);
        check("level4_const", BG_RGB, 8'h08);
        repeat (4) tick(1, 1, 200, 300);
        tick(0, 1, 5, 200);
        check("black_const", BG_RGB, 8'h00);
        repeat (9) tick(1, 1, 5, 200);
        tick(0, 1, 5, 200);
        check("mode1_border_const", BG_RGB, 8'hFF);
        check("idle_const", {7'b0, fadeBusy}, 8'h00);
        tick(0, 1, 320, 240);
        tick(0, 1, 639, 479);
        tick(0, 1, 640, 0);
        tick(1, 1, 320, 240);
        // Fade to checkerboard.
        repeat (18) tick(1, 2, 50, 60);
        tick(0, 2, 0, 0);
        check("chk00_const", BG_RGB, 8'h92);
        tick(0, 2, 32, 0);
        tick(0, 2, 32, 32);
        // Fade to stripes with requests changing mid-fade; then the final request re-fades.
        tick(1, 3, 10, 10);
        repeat (4) tick(1, 1, 10, 10);
        repeat (12) tick(1, 0, 29, 10);
        for (int i = 0; i < 40; i++) tick(0, 0, 11'(i * 16), 11'(i * 11));
        repeat (5) tick(1, 0, 29, 10);
        tick(1, 2, 29, 10);
        // Asynchronous reset mid fade-out.
        resetN = 1'b0;
        #1;
        check("midreset_rgb", BG_RGB, 8'h00);
        check("midreset_busy", {7'b0, fadeBusy}, 8'h00);
        model_reset();
        @(negedge clk);
        resetN = 1'b1;
        tick(0, 0, 100, 100);
        check("post_reset_const", BG_RGB, 8'h10);
        // Move to stripes, then run the scroll offset through a full wrap.
        repeat (18) tick(1, 3, 29, 0);
        for (int i = 0; i < 660; i++) tick(1, 3, 11'($urandom_range(0, 660)), 11'($urandom_range(0, 500)));
        // Randomized mixed traffic.
        bg = 2'd3;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 39) == 0) bg = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0)
                tick($urandom_range(0, 3) == 0, bg, 11'(edge_x[$urandom_range(0, 6)]), 11'(edge_y[$urandom_range(0, 4)]));
            else
                tick($urandom_range(0, 3) == 0, bg, 11'($urandom_range(0, 700)), 11'($urandom_range(0, 520)));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
